// File: rtl/conv_stream_layer.sv
// Streaming single-channel 2-D convolution layer.
// Raster-order pixels enter on a valid/ready stream. K-1 line buffers and a
// KxK window feed a parallel MAC, followed by requantise and activation.
// Kernel port layout: weight [r][c] occupies kernel[(r*K+c)*KDATA_WIDTH +: KDATA_WIDTH].
module conv_stream_layer #(
  parameter int    DATA_WIDTH  = 8,
  parameter int    KDATA_WIDTH = 8,
  parameter int    KERNEL_SIZE = 5,
  parameter int    IMGROW      = 28,
  parameter int    IMGCOL      = 28,
  parameter int    STRIDE      = 1,
  parameter int    OUT_SHIFT   = 0,
  parameter string ACTIVATION  = "RELU"
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*KDATA_WIDTH-1:0]  kernel,
  input  logic [KDATA_WIDTH-1:0]                          bias,
  input  logic                                            kernel_ld,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [DATA_WIDTH-1:0]                           in_pixel,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [DATA_WIDTH-1:0]                           out_data,
  output logic                                            out_last,
  output logic                                            layer_done_out
);

  localparam int K         = KERNEL_SIZE;
  localparam int KK        = K * K;
  localparam int DW        = DATA_WIDTH;
  localparam int KW        = KDATA_WIDTH;
  localparam int ACC_WIDTH = DW + KW + $clog2(KK) + 1;
  localparam int RW        = $clog2(IMGROW);
  localparam int CW        = $clog2(IMGCOL);
  // Position of the final window actually produced; with STRIDE > 1 the
  // bottom-right pixel may not complete a window, so last is tied to this.
  localparam int LAST_ROW  = (K - 1) + ((IMGROW - K) / STRIDE) * STRIDE;
  localparam int LAST_COL  = (K - 1) + ((IMGCOL - K) / STRIDE) * STRIDE;
  localparam bit USE_RELU  = (ACTIVATION == "RELU");

  localparam logic signed [ACC_WIDTH-1:0] U_MAX = ACC_WIDTH'((64'd1 << DW) - 64'd1);
  localparam logic signed [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'((64'd1 << (DW - 1)) - 64'd1);
  localparam logic signed [ACC_WIDTH-1:0] S_MIN = ~S_MAX;

  // Control
  logic en;
  logic accept;
  logic idle;
  logic load;

  // Raster position
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  int            row_i, col_i;
  logic          hit, hit_last;

  // Line buffers, window and stage-1 flags
  logic [DW-1:0] lb_q    [K-1][IMGCOL];
  logic [DW-1:0] col_vec [K];
  logic [DW-1:0] win_q   [K][K];
  logic [DW-1:0] win_d   [K][K];
  logic          s1_valid_q, s1_valid_d;
  logic          s1_last_q,  s1_last_d;

  // Weights
  logic [KK*KW-1:0] kern_q;
  logic [KW-1:0]    bias_q;

  // Arithmetic
  logic signed [ACC_WIDTH-1:0] px_ext [K][K];
  logic signed [ACC_WIDTH-1:0] wt_ext [K][K];
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_sh;
  logic [DW-1:0]               act;

  // Stage 2 / output registers
  logic          out_valid_q, out_valid_d;
  logic          out_last_q,  out_last_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic          done_q,      done_d;

  assign en       = !out_valid_q || out_ready;
  assign accept   = in_valid && en;
  assign idle     = (row_q == '0) && (col_q == '0) && !s1_valid_q && !out_valid_q;
  assign load     = kernel_ld && idle;

  assign in_ready       = en;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign out_data       = out_data_q;
  assign layer_done_out = done_q;

  // Raster counters advance on every accepted pixel, wrapping into the next frame.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (col_q == CW'(IMGCOL - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMGROW - 1)) row_d = '0;
        else                          row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Decide whether the current pixel completes a strided output window.
  always_comb begin
    row_i    = int'(row_q);
    col_i    = int'(col_q);
    hit      = (row_i >= K - 1) && (col_i >= K - 1) &&
               (((row_i - (K - 1)) % STRIDE) == 0) &&
               (((col_i - (K - 1)) % STRIDE) == 0);
    hit_last = hit && (row_i == LAST_ROW) && (col_i == LAST_COL);
  end

  // Column of K vertically adjacent pixels: oldest row first, incoming pixel last.
  always_comb begin
    for (int unsigned r = 0; r < K - 1; r++) col_vec[r] = lb_q[r][col_q];
    col_vec[K-1] = in_pixel;
  end

  // Line buffers shift up one row in the current column on each accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < K - 1; k++) lb_q[k][col_q] <= col_vec[k + 1];
    end
  end

  // Window shifts left by one column on accept; stage 1 holds when stalled.
  always_comb begin
    win_d      = win_q;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    if (en) begin
      if (accept) begin
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c + 1];
          win_d[r][K-1] = col_vec[r];
        end
        s1_valid_d = hit;
        s1_last_d  = hit_last;
      end else begin
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
      end
    end
  end

  // Stage-1 state: position counters, window and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q      <= '0;
      col_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++) win_q[r][c] <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      win_q      <= win_d;
    end
  end

  // Weight registers load only between frames so a frame never mixes kernels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kern_q <= '0;
      bias_q <= '0;
    end else if (load) begin
      kern_q <= kernel;
      bias_q <= bias;
    end
  end

  // Extend operands to accumulator width: pixels unsigned, weights signed.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        px_ext[r][c] = $signed({{(ACC_WIDTH - DW){1'b0}}, win_q[r][c]});
        wt_ext[r][c] = $signed({{(ACC_WIDTH - KW){kern_q[(r*K + c)*KW + KW - 1]}},
                                kern_q[(r*K + c)*KW +: KW]});
      end
    end
  end

  // Exact multiply-accumulate, then arithmetic shift and saturating activation.
  always_comb begin
    acc = $signed({{(ACC_WIDTH - KW){bias_q[KW-1]}}, bias_q});
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        acc = acc + px_ext[r][c] * wt_ext[r][c];
    acc_sh = acc >>> OUT_SHIFT;
    if (USE_RELU) begin
      if (acc_sh < 0)          act = '0;
      else if (acc_sh > U_MAX) act = '1;
      else                     act = acc_sh[DW-1:0];
    end else begin
      if (acc_sh > S_MAX)      act = {1'b0, {(DW - 1){1'b1}}};
      else if (acc_sh < S_MIN) act = {1'b1, {(DW - 1){1'b0}}};
      else                     act = acc_sh[DW-1:0];
    end
  end

  // Stage 2 advances only when the output slot is free or being drained.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = out_valid_q && out_ready && out_last_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_last_q;
      out_data_d  = act;
    end
  end

  // Output registers and frame-done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_stream_layer.sv
// Directed bench for conv_stream_layer on 6x6 frames with a 3x3 kernel.
// Four instances cover stride 1/2, output shift and both activations.
module tb_conv_stream_layer;

  localparam int N = 4;
  localparam logic [71:0] K_ID   = 72'h00_0000_0001_0000_0000;
  localparam logic [71:0] K_ONES = {9{8'h01}};
  localparam logic [71:0] K_NEG  = {9{8'hFF}};
  localparam logic [71:0] K_ZERO = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic [71:0]   kernel;
  logic [7:0]    bias;
  logic          kld;
  logic [7:0]    in_pixel;
  logic [N-1:0]  iv, ordy, ir, ov, ol, dn;
  logic [7:0]    od [N];

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt [N];
  bit   chk_inv  = 1'b0;
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [7:0] id_vals [16] = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd15, 8'd16,
                               8'd19, 8'd20, 8'd21, 8'd22, 8'd25, 8'd26, 8'd27, 8'd28};

  always #5 clk = ~clk;

  conv_stream_layer #(.DATA_WIDTH(8), .KDATA_WIDTH(8), .KERNEL_SIZE(3), .IMGROW(6), .IMGCOL(6),
                      .STRIDE(1), .OUT_SHIFT(0), .ACTIVATION("RELU")) u_a (
    .clk(clk), .rst(rst), .kernel(kernel), .bias(bias), .kernel_ld(kld),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_pixel(in_pixel),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_last(ol[0]),
    .layer_done_out(dn[0]));

  conv_stream_layer #(.DATA_WIDTH(8), .KDATA_WIDTH(8), .KERNEL_SIZE(3), .IMGROW(6), .IMGCOL(6),
                      .STRIDE(2), .OUT_SHIFT(0), .ACTIVATION("RELU")) u_b (
    .clk(clk), .rst(rst), .kernel(kernel), .bias(bias), .kernel_ld(kld),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_pixel(in_pixel),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_last(ol[1]),
    .layer_done_out(dn[1]));

  conv_stream_layer #(.DATA_WIDTH(8), .KDATA_WIDTH(8), .KERNEL_SIZE(3), .IMGROW(6), .IMGCOL(6),
                      .STRIDE(1), .OUT_SHIFT(4), .ACTIVATION("RELU")) u_c (
    .clk(clk), .rst(rst), .kernel(kernel), .bias(bias), .kernel_ld(kld),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_pixel(in_pixel),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_last(ol[2]),
    .layer_done_out(dn[2]));

  conv_stream_layer #(.DATA_WIDTH(8), .KDATA_WIDTH(8), .KERNEL_SIZE(3), .IMGROW(6), .IMGCOL(6),
                      .STRIDE(1), .OUT_SHIFT(0), .ACTIVATION("NONE")) u_d (
    .clk(clk), .rst(rst), .kernel(kernel), .bias(bias), .kernel_ld(kld),
    .in_valid(iv[3]), .in_ready(ir[3]), .in_pixel(in_pixel),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .out_last(ol[3]),
    .layer_done_out(dn[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample outputs, then advance to next negedge.
  task automatic drive_cycle(input int inst, input logic v, input logic [7:0] pix,
                             input logic rdy, output logic accepted);
    iv         = '0;
    ordy       = '1;
    iv[inst]   = v;
    ordy[inst] = rdy;
    in_pixel   = pix;
    #1;
    accepted = v & ir[inst];
    if (ov[inst] && ordy[inst]) begin
      got_q.push_back(od[inst]);
      got_last_q.push_back(ol[inst]);
    end
    for (int i = 0; i < N; i++) if (dn[i]) done_cnt[i]++;
    if (chk_inv) check("in_ready_vs_stall", {31'd0, ir[inst]}, {31'd0, !(ov[inst] && !ordy[inst])});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input int inst, input int npix, input logic cst,
                            input logic [7:0] cval, input logic bp, input int kld_at);
    int   idx;
    int   cyc;
    logic acc;
    logic v;
    logic rdy;
    idx = 0;
    cyc = 0;
    while (idx < npix && cyc < 4000) begin
      v   = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (idx == kld_at) begin
        kernel = K_ZERO;
        kld    = 1'b1;
      end else begin
        kld = 1'b0;
      end
      drive_cycle(inst, v, cst ? cval : 8'(idx % 36), rdy, acc);
      if (acc) idx++;
      cyc++;
    end
    kld = 1'b0;
    check("pixels_accepted_in_budget", idx, npix);
  endtask

  task automatic drain(input int inst);
    logic acc;
    for (int i = 0; i < 8; i++) drive_cycle(inst, 1'b0, 8'd0, 1'b1, acc);
  endtask

  task automatic load_kernel(input logic [71:0] k);
    kernel = k;
    bias   = 8'd0;
    kld    = 1'b1;
    iv     = '0;
    ordy   = '1;
    @(posedge clk);
    @(negedge clk);
    kld = 1'b0;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_last_q.delete();
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
  endtask

  task automatic exp_const(input logic [7:0] v);
    exp_q.delete();
    exp_last_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(v);
      exp_last_q.push_back(i == 15);
    end
  endtask

  task automatic exp_identity(input int frames);
    exp_q.delete();
    exp_last_q.delete();
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < 16; i++) begin
        exp_q.push_back(id_vals[i]);
        exp_last_q.push_back(i == 15);
      end
  endtask

  task automatic compare(input string tag, input int inst, input int ndone);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_data"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      check({tag, "_last"}, {31'd0, got_last_q[i]}, {31'd0, exp_last_q[i]});
    end
    check({tag, "_done_pulses"}, done_cnt[inst], ndone);
    clear_obs();
  endtask

  initial begin
    rst      = 1'b0;
    kernel   = '0;
    bias     = '0;
    kld      = 1'b0;
    in_pixel = '0;
    iv       = '0;
    ordy     = '1;
    clear_obs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_out_valid", {31'd0, ov[0]}, 32'd0);
    check("reset_out_data",  {24'd0, od[0]}, 32'd0);
    check("reset_out_last",  {31'd0, ol[0]}, 32'd0);
    check("reset_done",      {31'd0, dn[0]}, 32'd0);
    check("reset_in_ready",  {31'd0, ir[0]}, 32'd1);
    @(negedge clk);

    // Identity kernel, stride 1
    load_kernel(K_ID);
    send_frame(0, 36, 1'b0, 8'd0, 1'b0, -1);
    drain(0);
    exp_identity(1);
    compare("identity", 0, 1);

    // Identity kernel, stride 2
    send_frame(1, 36, 1'b0, 8'd0, 1'b0, -1);
    drain(1);
    exp_q      = '{8'd7, 8'd9, 8'd19, 8'd21};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    compare("stride2", 1, 1);

    // All-ones kernel on saturated pixels: RELU clamp, and shift by 4
    load_kernel(K_ONES);
    send_frame(0, 36, 1'b1, 8'd255, 1'b0, -1);
    drain(0);
    exp_const(8'd255);
    compare("relu_sat_high", 0, 1);
    send_frame(2, 36, 1'b1, 8'd255, 1'b0, -1);
    drain(2);
    exp_const(8'd143);
    compare("shift4", 2, 1);

    // All -1 kernel: RELU floors at 0, NONE saturates to -128
    load_kernel(K_NEG);
    send_frame(0, 36, 1'b1, 8'd255, 1'b0, -1);
    drain(0);
    exp_const(8'd0);
    compare("relu_neg", 0, 1);
    send_frame(3, 36, 1'b1, 8'd255, 1'b0, -1);
    drain(3);
    exp_const(8'h80);
    compare("none_sat_low", 3, 1);

    // Backpressure with gapped input
    load_kernel(K_ID);
    chk_inv = 1'b1;
    send_frame(0, 36, 1'b0, 8'd0, 1'b1, -1);
    chk_inv = 1'b0;
    drain(0);
    exp_identity(1);
    compare("backpressure", 0, 1);

    // Reset mid-frame, then a clean frame
    send_frame(0, 20, 1'b1, 8'd200, 1'b0, -1);
    rst = 1'b0;
    #2;
    check("midrst_out_valid", {31'd0, ov[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    load_kernel(K_ID);
    send_frame(0, 36, 1'b0, 8'd0, 1'b0, -1);
    drain(0);
    exp_identity(1);
    compare("after_reset", 0, 1);

    // Two frames back-to-back
    send_frame(0, 72, 1'b0, 8'd0, 1'b0, -1);
    drain(0);
    exp_identity(2);
    compare("back_to_back", 0, 2);

    // kernel_ld in mid-frame must not change weights
    send_frame(0, 36, 1'b0, 8'd0, 1'b0, 10);
    kernel = K_ID;
    drain(0);
    exp_identity(1);
    compare("kld_midframe", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
